// File: rtl/gain_restore.sv
// gain_restore: iterative shift-add multiplier that scales a signed sample by an unsigned fixed-point gain.
// Optional macro GAIN_RESTORE_ROUND_EN selects round-half-up before the fractional shift (default: floor).
module gain_restore #(
  parameter int DATA_W = 14,
  parameter int COEF_W = 8,
  parameter int FRAC_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [COEF_W-1:0] in_coef,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat
);

  localparam int ACC_W = DATA_W + COEF_W;
  localparam int CNT_W = (COEF_W > 1) ? $clog2(COEF_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(COEF_W - 1);
  localparam logic signed [ACC_W-1:0] MAX_V = {{(COEF_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(COEF_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`ifdef GAIN_RESTORE_ROUND_EN
  localparam logic signed [ACC_W-1:0] BIAS = ACC_W'(1) << (FRAC_W - 1);
`else
  localparam logic signed [ACC_W-1:0] BIAS = '0;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, SAT, HOLD} state_t;

  state_t                   state, next_state;
  logic signed [ACC_W-1:0]  sample, acc, rounded, shifted;
  logic [COEF_W-1:0]        coef;
  logic [CNT_W-1:0]         cnt;
  logic [DATA_W-1:0]        clip_data;
  logic                     clip_sat;

  assign in_ready = (state == IDLE);

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (in_valid) next_state = BUSY;
      BUSY: if (cnt == LAST_BIT) next_state = SAT;
      SAT:  next_state = HOLD;
      HOLD: if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Accumulator width guarantees the bias add and the shift never overflow before clipping.
  always_comb begin
    rounded   = acc + BIAS;
    shifted   = rounded >>> FRAC_W;
    clip_data = shifted[DATA_W-1:0];
    clip_sat  = 1'b0;
    if (shifted > MAX_V) begin
      clip_data = MAX_V[DATA_W-1:0];
      clip_sat  = 1'b1;
    end else if (shifted < MIN_V) begin
      clip_data = MIN_V[DATA_W-1:0];
      clip_sat  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample    <= '0;
      coef      <= '0;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sample <= {{COEF_W{in_data[DATA_W-1]}}, in_data};
            coef   <= in_coef;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        BUSY: begin
          if (coef[cnt]) acc <= acc + (sample <<< cnt);
          cnt <= cnt + CNT_W'(1);
        end
        SAT: begin
          out_data  <= clip_data;
          out_sat   <= clip_sat;
          out_valid <= 1'b1;
        end
        HOLD: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gain_restore.sv
// Scoreboard testbench for gain_restore: directed corner cases, backpressure, mid-flight reset, random traffic.
module tb_gain_restore;

  localparam int DATA_W = 14;
  localparam int COEF_W = 8;
  localparam int FRAC_W = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [COEF_W-1:0] in_coef;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sat;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rand_ready = 1'b0;
  bit prev_valid = 1'b0;
  logic [DATA_W:0] exp_q[$];
  int lat_q[$];

  gain_restore #(.DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC_W(FRAC_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_coef(in_coef),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact product, optional half-LSB bias, floor division by 2^FRAC_W, then saturate.
  function automatic logic [DATA_W:0] model(int d, int c);
    longint p, q;
    logic sat;
    p = longint'(d) * longint'(c);
`ifdef GAIN_RESTORE_ROUND_EN
    p = p + longint'(2 ** (FRAC_W - 1));
`endif
    q = p / longint'(2 ** FRAC_W);
    if ((p % longint'(2 ** FRAC_W) != 0) && (p < 0)) q = q - 1;
    sat = 1'b0;
    if (q > longint'(2 ** (DATA_W - 1) - 1)) begin
      q = longint'(2 ** (DATA_W - 1) - 1);
      sat = 1'b1;
    end else if (q < -longint'(2 ** (DATA_W - 1))) begin
      q = -longint'(2 ** (DATA_W - 1));
      sat = 1'b1;
    end
    return {sat, q[DATA_W-1:0]};
  endfunction

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic report_missing(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got none expected event (t=%0t)", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic apply_stimulus(input int d, input int c);
    bit done = 1'b0;
    in_data  = DATA_W'(d);
    in_coef  = COEF_W'(c);
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      if (in_ready) begin
        exp_q.push_back(model(d, c));
        lat_q.push_back(cyc + 1);
        done = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!done) report_missing("accept_timeout");
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) report_missing("drain_timeout");
  endtask

  // Monitor: latency on each out_valid rise, value and stability every valid cycle, pop on handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (lat_q.size() == 0) report_missing("latency_entry");
        else check_output("latency", cyc - lat_q.pop_front(), COEF_W + 1);
      end
      if (out_valid) begin
        check_output("in_ready_while_valid", int'(in_ready), 0);
        if (exp_q.size() == 0) report_missing("unexpected_output");
        else begin
          check_output("out_data", int'($signed(out_data)), int'($signed(exp_q[0][DATA_W-1:0])));
          check_output("out_sat", int'(out_sat), int'(exp_q[0][DATA_W]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    bit seen;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_coef = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_output("reset_in_ready", int'(in_ready), 1);
    check_output("reset_out_valid", int'(out_valid), 0);
    check_output("reset_out_data", int'(out_data), 0);
    check_output("reset_out_sat", int'(out_sat), 0);
    rst = 1'b0;
    tick();

    apply_stimulus(1000, 158);
    apply_stimulus(-1000, 158);
    apply_stimulus(4000, 158);
    apply_stimulus(-8192, 158);
    apply_stimulus(1234, 64);
    apply_stimulus(-5, 0);
    apply_stimulus(8191, 255);
    apply_stimulus(-8192, 255);
    wait_drain();

    // Backpressure: output held while in_valid pulses must be ignored.
    out_ready = 1'b0;
    apply_stimulus(777, 200);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (out_valid) seen = 1'b1;
      else tick();
    end
    if (!seen) report_missing("hold_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data  = DATA_W'(100 + i);
      in_coef  = 8'd64;
      tick();
      check_output("hold_out_valid", int'(out_valid), 1);
      check_output("hold_in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_output("post_hs_out_valid", int'(out_valid), 0);
    check_output("post_hs_in_ready", int'(in_ready), 1);
    wait_drain();

    // Reset while BUSY with cnt=3 discards the in-flight sample.
    apply_stimulus(3000, 100);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check_output("midrst_in_ready", int'(in_ready), 1);
    check_output("midrst_out_valid", int'(out_valid), 0);
    check_output("midrst_out_data", int'(out_data), 0);
    check_output("midrst_out_sat", int'(out_sat), 0);
    exp_q.delete();
    lat_q.delete();
    tick();
    rst = 1'b0;
    tick();
    apply_stimulus(-3000, 100);
    apply_stimulus(2500, 99);
    wait_drain();

    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) tick();
    end
    wait_drain();
    rand_ready = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
